arbiter_rr_n: RTL
=================

ARBITER_RR_N -- requirements
Module: arbiter_rr_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter SIZE, default 16, memory depth in words.
REQ-003 SHALL have parameter IDX_SIZE, default 4, address width.
REQ-004 SHALL have parameter PORTS, default 4, requester count, legal range 2..16.
REQ-005 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port addr  in  PORTS*IDX_SIZE  per-port address; port p occupies bits [p*IDX_SIZE +: IDX_SIZE].
REQ-008 SHALL have ports read_en and write_en  in  PORTS  per-port level requests, held until the matching done.
REQ-009 SHALL have port in  in  PORTS*WIDTH  per-port write data, packed like addr.
REQ-010 SHALL have ports mem_read_done, mem_write_done  in  1 and mem_out  in  WIDTH  memory completion and read data.
REQ-011 SHALL have port out  out  PORTS*WIDTH  per-port registered read data.
REQ-012 SHALL have ports read_done, write_done  out  PORTS  per-port registered completion flags.
REQ-013 SHALL have ports mem_addr  out  IDX_SIZE, mem_in  out  WIDTH, mem_read_en  out  1, mem_write_en  out  1  to the single memory port.

Function
REQ-014 SHALL implement one FSM: IDLE, READ, WRITE, RESP; exactly one memory operation is outstanding at any time; mem_read_en and mem_write_en are never both high.
REQ-015 SHALL, in IDLE, treat port p as requesting when read_en[p] | write_en[p]; if both set on one port, the read is serviced first.
REQ-016 SHALL choose the grant round-robin: first requesting port at or after pointer ptr, wrapping PORTS-1 -> 0.
REQ-017 SHALL, on grant of port g in cycle N, register mem_addr, mem_in (writes), assert mem_*_en from cycle N+1, clear read_done[g]/write_done[g], and enter READ or WRITE.
REQ-018 SHALL hold mem_*_en, mem_addr, mem_in stable in READ/WRITE until the matching mem_*_done; the non-matching done is ignored.
REQ-019 SHALL, on mem_read_done in READ, latch mem_out into out slice g, set read_done[g], drop mem_read_en, next cycle; likewise for writes with write_done[g].
REQ-020 SHALL set ptr to (g+1) mod PORTS on completion and enter RESP for exactly one cycle, issuing no grant, so the completed port can drop its request.
REQ-021 SHALL return RESP -> IDLE unconditionally; done flags stay set until that port is granted again.
REQ-022 SHALL leave out slices of non-granted ports unchanged; simultaneous requests from all ports are served in ptr order, each within PORTS operations (no starvation).
REQ-023 SHALL drive mem_addr to 0 whenever idle or in RESP.

Reset
REQ-024 SHALL, with reset high at a rising edge, force state IDLE, ptr 0, out all 0, read_done and write_done 0, mem_addr 0, mem_in 0, mem_read_en 0, mem_write_en 0.
REQ-025 SHALL abandon any in-flight operation on reset mid-operation; no done is raised for it, and memory done pulses in the cycle after reset are ignored.

Configuration
REQ-026 SHALL support macro ARBITER_READ_PRIORITY_EN: when defined, any pending read on any port is granted before any write (round-robin among reads, then among writes); when undefined, arbitration is purely round-robin per REQ-015/016.

Verification
REQ-027 SHALL cover: reset, then read_en[1]=1 addr1=5, mem_read_done after 3 cycles with mem_out=0xCAFE -> mem_read_en high cycles 1..3, out slice 1=0xCAFE, read_done[1]=1, ptr=2.
REQ-028 SHALL cover: all four ports write_en=1 simultaneously, in=p+0x10, 1-cycle memory -> grants in order 0,1,2,3, each write_done set once, mem_in values 0x10..0x13 in order.
REQ-029 SHALL cover: port 2 read_en and write_en both 1 -> read serviced first, then write; never both mem enables high.
REQ-030 SHALL cover: with ARBITER_READ_PRIORITY_EN, write_en[0] and read_en[3] together at ptr=0 -> port 3 read granted first; without macro -> port 0 write granted first.
REQ-031 SHALL cover: reset asserted while in WRITE with mem_write_done pending -> mem_write_en 0 next cycle, write_done all 0, state IDLE, ptr 0.

Source files
------------

// File: rtl/arbiter_rr_n.sv
// Round-robin arbiter giving PORTS requesters shared access to a single memory port, one operation at a time.
// Optional macro ARBITER_READ_PRIORITY_EN: pending reads are granted ahead of all writes.
module arbiter_rr_n #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4,
  parameter int PORTS    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PORTS*IDX_SIZE-1:0] addr,
  input  logic [PORTS-1:0]          read_en,
  input  logic [PORTS-1:0]          write_en,
  input  logic [PORTS*WIDTH-1:0]    in,
  input  logic                      mem_read_done,
  input  logic                      mem_write_done,
  input  logic [WIDTH-1:0]          mem_out,
  output logic [PORTS*WIDTH-1:0]    out,
  output logic [PORTS-1:0]          read_done,
  output logic [PORTS-1:0]          write_done,
  output logic [IDX_SIZE-1:0]       mem_addr,
  output logic [WIDTH-1:0]          mem_in,
  output logic                      mem_read_en,
  output logic                      mem_write_en
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  if (PORTS < 2 || PORTS > 16 || SIZE > (1 << IDX_SIZE)) begin : g_bad_cfg
    $error("arbiter_rr_n: PORTS must be 2..16 and SIZE must fit in IDX_SIZE address bits");
  end

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t        state, state_next;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] pick;
  logic          pick_vld;
  logic          pick_rd;

  // First set bit of v scanning upward from p with wrap; MSB of result flags "found".
  function automatic logic [PW:0] rr_pick(input logic [PORTS-1:0] v, input logic [PW-1:0] p);
    logic          found;
    logic [PW-1:0] g;
    int            k;
    found = 1'b0;
    g     = '0;
    for (int i = 0; i < PORTS; i++) begin
      k = (int'(p) + i) % PORTS;
      if (!found && v[k]) begin
        found = 1'b1;
        g     = PW'(k);
      end
    end
    return {found, g};
  endfunction

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] g);
    return (int'(g) == PORTS - 1) ? '0 : g + 1'b1;
  endfunction

  always_comb begin
    state_next = state;
    pick_vld   = 1'b0;
    pick       = '0;
    pick_rd    = 1'b0;
    case (state)
      IDLE: begin
`ifdef ARBITER_READ_PRIORITY_EN
        if (|read_en) begin
          {pick_vld, pick} = rr_pick(read_en, ptr);
          pick_rd          = 1'b1;
        end else begin
          {pick_vld, pick} = rr_pick(write_en, ptr);
          pick_rd          = 1'b0;
        end
`else
        {pick_vld, pick} = rr_pick(read_en | write_en, ptr);
        // A port asking for both is served as a read first.
        pick_rd          = read_en[pick];
`endif
        if (pick_vld) state_next = pick_rd ? READ : WRITE;
      end
      READ:    if (mem_read_done)  state_next = RESP;
      WRITE:   if (mem_write_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= '0;
      gnt          <= '0;
      out          <= '0;
      read_done    <= '0;
      write_done   <= '0;
      mem_addr     <= '0;
      mem_in       <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt              <= pick;
            mem_addr         <= addr[pick*IDX_SIZE +: IDX_SIZE];
            if (!pick_rd) mem_in <= in[pick*WIDTH +: WIDTH];
            mem_read_en      <= pick_rd;
            mem_write_en     <= !pick_rd;
            read_done[pick]  <= 1'b0;
            write_done[pick] <= 1'b0;
          end
        end
        READ: begin
          if (mem_read_done) begin
            out[gnt*WIDTH +: WIDTH] <= mem_out;
            read_done[gnt]          <= 1'b1;
            mem_read_en             <= 1'b0;
            mem_addr                <= '0;
            ptr                     <= inc_ptr(gnt);
          end
        end
        WRITE: begin
          if (mem_write_done) begin
            write_done[gnt] <= 1'b1;
            mem_write_en    <= 1'b0;
            mem_addr        <= '0;
            ptr             <= inc_ptr(gnt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
